// File: rtl/fpu_iter_div_sqrt_mant.sv
// ---------------------------------------------------------------------------
// fpu_iter_div_sqrt_mant
//   Iterative radix-2 restoring mantissa divider / square-rooter. Produces one
//   quotient bit per cycle, C_ITER = C_MANT+1+C_RB bits in total, and hands the
//   pre-normalised mantissa, the round bits (LSB sticky) and the signed biased
//   exponent to the downstream normaliser/rounder. Special operands are flagged
//   elsewhere, so this block always runs the full iteration count.
//
// Ports
//   Clk_CI, Rst_RI        clock, synchronous active-high reset
//   Div_start_SI          launch a division (wins over Sqrt_start_SI)
//   Sqrt_start_SI         launch a square root
//   Kill_SI               abort; return to idle without Done_SO
//   Mant_a_DI/Mant_b_DI   normalised mantissas, hidden bit at MSB
//   Exp_a_DI/Exp_b_DI     signed biased exponents (C_EXP+2 bits)
//   Sign_a_DI/Sign_b_DI   operand signs
//   Ready_SO              idle, a start is accepted this cycle
//   Done_SO               one-cycle pulse, result outputs valid
//   Mant_res_DO           Q[C_ITER-1:C_RB], MSB is the integer bit
//   Round_bit_DO          {Q[C_RB-1:1], Q[0] | (remainder != 0)}
//   Exp_res_DO            signed biased result exponent
//   Sign_res_DO           div: Sign_a^Sign_b, sqrt: Sign_a
// ---------------------------------------------------------------------------
module fpu_iter_div_sqrt_mant #(
    parameter int C_MANT = 23,
    parameter int C_EXP  = 8,
    parameter int C_BIAS = 127,
    parameter int C_RB   = 4
) (
    input  logic               Clk_CI,
    input  logic               Rst_RI,
    input  logic               Div_start_SI,
    input  logic               Sqrt_start_SI,
    input  logic               Kill_SI,
    input  logic [C_MANT:0]    Mant_a_DI,
    input  logic [C_MANT:0]    Mant_b_DI,
    input  logic [C_EXP+1:0]   Exp_a_DI,
    input  logic [C_EXP+1:0]   Exp_b_DI,
    input  logic               Sign_a_DI,
    input  logic               Sign_b_DI,
    output logic               Ready_SO,
    output logic               Done_SO,
    output logic [C_MANT:0]    Mant_res_DO,
    output logic [C_RB-1:0]    Round_bit_DO,
    output logic [C_EXP+1:0]   Exp_res_DO,
    output logic               Sign_res_DO
);

    localparam int MW = C_MANT + 1;      // datapath mantissa incl. hidden bit
    localparam int EW = C_EXP + 2;       // signed exponent datapath
    localparam int NI = MW + C_RB;       // quotient bits / iterations
    localparam int CW = $clog2(NI);
    localparam int XW = 2 * NI;          // sqrt radicand, two bits per step
    // Sqrt partial remainder stays below 2*Q+1 (NI+1 bits); after appending
    // two radicand bits it needs NI+3 bits. One spare bit on top of that.
    localparam int RW = NI + 4;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [RW-1:0]         rem;
    logic [NI-1:0]         quo;
    logic [XW-1:0]         x_sr;      // radicand, consumed from the MSB end
    logic [MW-1:0]         divisor;
    logic                  is_sqrt;
    logic [EW-1:0]         exp_q;
    logic                  sign_q;

    // ------------------------------------------------------------------
    // Result exponent, computed once at launch
    // ------------------------------------------------------------------
    logic signed [EW-1:0]  exp_a_s, exp_b_s, exp_div, exp_sqrt_sum, exp_sqrt;

    assign exp_a_s      = $signed(Exp_a_DI);
    assign exp_b_s      = $signed(Exp_b_DI);
    assign exp_div      = exp_a_s - exp_b_s + $signed(EW'(C_BIAS));
    // Even exponent: mantissa was pre-shifted left one bit, so drop one
    // from the exponent to keep the halving exact.
    assign exp_sqrt_sum = exp_a_s + $signed(EW'(C_BIAS)) - $signed(EW'(!Exp_a_DI[0]));
    assign exp_sqrt     = exp_sqrt_sum >>> 1;

    // ------------------------------------------------------------------
    // One restoring step
    // ------------------------------------------------------------------
    logic [RW-1:0]         d_ext, t_val, r_cat, r_sub, rem_nxt;
    logic                  q_bit;
    logic [NI-1:0]         quo_nxt;

    always_comb begin
        d_ext   = RW'(divisor);
        t_val   = {{(RW-NI-2){1'b0}}, quo, 2'b01};
        r_cat   = {rem[RW-3:0], x_sr[XW-1 -: 2]};
        r_sub   = rem;
        q_bit   = 1'b0;
        rem_nxt = rem;
        if (is_sqrt) begin
            q_bit   = (r_cat >= t_val);
            rem_nxt = q_bit ? (r_cat - t_val) : r_cat;
        end else begin
            // Divisor of zero gives q=1 every step; remainder just wraps.
            q_bit   = (rem >= d_ext);
            r_sub   = q_bit ? (rem - d_ext) : rem;
            rem_nxt = r_sub << 1;
        end
        quo_nxt = {quo[NI-2:0], q_bit};
    end

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state        <= IDLE;
            Ready_SO     <= 1'b1;
            Done_SO      <= 1'b0;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            x_sr         <= '0;
            divisor      <= '0;
            is_sqrt      <= 1'b0;
            exp_q        <= '0;
            sign_q       <= 1'b0;
            Mant_res_DO  <= '0;
            Round_bit_DO <= '0;
            Exp_res_DO   <= '0;
            Sign_res_DO  <= 1'b0;
        end else begin
            Done_SO <= 1'b0;
            if (Kill_SI) begin
                // Abort wins over everything, including a same-cycle start.
                state    <= IDLE;
                Ready_SO <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (Div_start_SI || Sqrt_start_SI) begin
                            state    <= ITER;
                            Ready_SO <= 1'b0;
                            cnt      <= '0;
                            quo      <= '0;
                            divisor  <= Mant_b_DI;
                            is_sqrt  <= !Div_start_SI;
                            x_sr     <= {(Exp_a_DI[0] ? {1'b0, Mant_a_DI} : {Mant_a_DI, 1'b0}),
                                         {(XW-MW-1){1'b0}}};
                            if (Div_start_SI) begin
                                rem    <= RW'(Mant_a_DI);
                                exp_q  <= exp_div;
                                sign_q <= Sign_a_DI ^ Sign_b_DI;
                            end else begin
                                rem    <= '0;
                                exp_q  <= exp_sqrt;
                                sign_q <= Sign_a_DI;
                            end
                        end
                    end
                    ITER: begin
                        rem  <= rem_nxt;
                        quo  <= quo_nxt;
                        x_sr <= x_sr << 2;
                        cnt  <= cnt + CW'(1);
                        if (cnt == CW'(NI-1)) begin
                            state        <= DONE;
                            Done_SO      <= 1'b1;
                            Mant_res_DO  <= quo_nxt[NI-1 -: MW];
                            Round_bit_DO <= {quo_nxt[C_RB-1:1], quo_nxt[0] | (|rem_nxt)};
                            Exp_res_DO   <= exp_q;
                            Sign_res_DO  <= sign_q;
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        Ready_SO <= 1'b1;
                    end
                    default: begin
                        state    <= IDLE;
                        Ready_SO <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_iter_div_sqrt_mant.sv
// ---------------------------------------------------------------------------
// tb_fpu_iter_div_sqrt_mant
//   Directed bench for the iterative mantissa divider / square-rooter.
//   Inputs are driven and outputs sampled on the falling edge; "cycle N"
//   means the interval after the N-th rising edge following the start.
// ---------------------------------------------------------------------------
module tb_fpu_iter_div_sqrt_mant;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start, sqrt_start, kill;
    logic [23:0] mant_a, mant_b;
    logic [9:0]  exp_a, exp_b;
    logic        sign_a, sign_b;
    logic        ready, done;
    logic [23:0] mant_res;
    logic [3:0]  round_bit;
    logic [9:0]  exp_res;
    logic        sign_res;

    int errors = 0;
    int checks = 0;

    fpu_iter_div_sqrt_mant dut (
        .Clk_CI        (clk),
        .Rst_RI        (rst),
        .Div_start_SI  (div_start),
        .Sqrt_start_SI (sqrt_start),
        .Kill_SI       (kill),
        .Mant_a_DI     (mant_a),
        .Mant_b_DI     (mant_b),
        .Exp_a_DI      (exp_a),
        .Exp_b_DI      (exp_b),
        .Sign_a_DI     (sign_a),
        .Sign_b_DI     (sign_b),
        .Ready_SO      (ready),
        .Done_SO       (done),
        .Mant_res_DO   (mant_res),
        .Round_bit_DO  (round_bit),
        .Exp_res_DO    (exp_res),
        .Sign_res_DO   (sign_res)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge in cycle 0; returns on the falling edge of cycle 1.
    task automatic launch(input logic ds, input logic ss, input logic [23:0] a, input logic [23:0] b,
                          input logic [9:0] ea, input logic [9:0] eb, input logic sa, input logic sb);
        div_start = ds; sqrt_start = ss;
        mant_a = a; mant_b = b; exp_a = ea; exp_b = eb; sign_a = sa; sign_b = sb;
        @(negedge clk);
        div_start = 1'b0; sqrt_start = 1'b0;
    endtask

    // Bounded wait for Done_SO; reports the cycle it arrived in.
    task automatic wait_done(input string tag, input int start_cyc);
        int cyc = start_cyc;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 29);
    endtask

    task automatic expect_res(input string tag, input logic [23:0] m, input logic [3:0] rb,
                              input logic [9:0] e, input logic s);
        chk({tag, "_mant"}, mant_res, m);
        chk({tag, "_rb"},   round_bit, rb);
        chk({tag, "_exp"},  exp_res, e);
        chk({tag, "_sign"}, sign_res, s);
    endtask

    task automatic no_done_for(input string tag, input int n);
        logic seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seen |= done;
        end
        chk(tag, seen, 1'b0);
    endtask

    initial begin
        rst = 1'b1; div_start = 0; sqrt_start = 0; kill = 0;
        mant_a = 0; mant_b = 0; exp_a = 0; exp_b = 0; sign_a = 0; sign_b = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_ready", ready, 1'b1);
        chk("rst_done",  done,  1'b0);
        expect_res("rst", 24'h0, 4'h0, 10'd0, 1'b0);
        @(negedge clk);

        // 1.0 / 1.5
        chk("div1_ready", ready, 1'b1);
        launch(1, 0, 24'h800000, 24'hC00000, 10'd127, 10'd127, 0, 0);
        chk("div1_busy", ready, 1'b0);
        wait_done("div1", 1);
        expect_res("div1", 24'h555555, 4'b0101, 10'd127, 1'b0);
        @(negedge clk);

        // 1.5 / 1.0 with signs 1/0, then back-to-back sqrt(4.0)
        launch(1, 0, 24'hC00000, 24'h800000, 10'd130, 10'd127, 1, 0);
        wait_done("div2", 1);
        expect_res("div2", 24'hC00000, 4'b0000, 10'd130, 1'b1);
        @(negedge clk);
        chk("b2b_ready", ready, 1'b1);
        chk("b2b_done_low", done, 1'b0);
        launch(0, 1, 24'h800000, 24'h0, 10'd129, 10'd0, 0, 1);
        wait_done("sqrt4", 1);
        expect_res("sqrt4", 24'h800000, 4'b0000, 10'd128, 1'b0);
        @(negedge clk);

        // sqrt(2.0), negative sign passed through
        launch(0, 1, 24'h800000, 24'h123456, 10'd128, 10'd5, 1, 0);
        wait_done("sqrt2", 1);
        expect_res("sqrt2", 24'hB504F3, 4'b0011, 10'd127, 1'b1);
        @(negedge clk);

        // Kill in cycle 10
        launch(1, 0, 24'hC00000, 24'h800000, 10'd140, 10'd100, 0, 0);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_ready", ready, 1'b1);
        chk("kill_done", done, 1'b0);
        expect_res("kill_hold", 24'hB504F3, 4'b0011, 10'd127, 1'b1);
        no_done_for("kill_no_done", 35);

        // Start while busy is ignored
        launch(1, 0, 24'h800000, 24'hC00000, 10'd127, 10'd127, 0, 0);
        repeat (4) @(negedge clk);
        chk("busy_ready", ready, 1'b0);
        div_start = 1; sqrt_start = 1;
        mant_a = 24'hC00000; mant_b = 24'h800000; exp_a = 10'd130; sign_a = 1;
        @(negedge clk);
        div_start = 0; sqrt_start = 0;
        wait_done("busy", 6);
        expect_res("busy", 24'h555555, 4'b0101, 10'd127, 1'b0);
        @(negedge clk);

        // Both starts: division wins
        launch(1, 1, 24'hC00000, 24'h800000, 10'd130, 10'd127, 0, 1);
        wait_done("both", 1);
        expect_res("both", 24'hC00000, 4'b0000, 10'd130, 1'b1);
        @(negedge clk);

        // Kill together with start: nothing launched
        kill = 1'b1;
        launch(1, 0, 24'h800000, 24'hC00000, 10'd10, 10'd20, 0, 0);
        kill = 1'b0;
        chk("killstart_ready", ready, 1'b1);
        no_done_for("killstart_no_done", 35);
        expect_res("killstart_hold", 24'hC00000, 4'b0000, 10'd130, 1'b1);

        // Divisor zero: all-ones quotient, normal latency
        launch(1, 0, 24'h800000, 24'h000000, 10'd127, 10'd127, 0, 0);
        wait_done("divz", 1);
        expect_res("divz", 24'hFFFFFF, 4'hF, 10'd127, 1'b0);
        @(negedge clk);

        // Negative result exponent wraps in 10-bit two's complement
        launch(1, 0, 24'hC00000, 24'h800000, 10'd1, 10'd200, 1, 1);
        wait_done("nexp", 1);
        expect_res("nexp", 24'hC00000, 4'b0000, 10'h3B8, 1'b0);
        @(negedge clk);

        // sqrt with negative even exponent (-4)
        launch(0, 1, 24'h800000, 24'h0, 10'h3FC, 10'd0, 0, 0);
        wait_done("sqrtn", 1);
        expect_res("sqrtn", 24'hB504F3, 4'b0011, 10'd61, 1'b0);
        @(negedge clk);

        // Reset mid-operation
        launch(1, 0, 24'hC00000, 24'h800000, 10'd130, 10'd127, 1, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_done", done, 1'b0);
        expect_res("midrst", 24'h0, 4'h0, 10'd0, 1'b0);
        no_done_for("midrst_no_done", 35);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
